// File: rtl/sump_cmd_decoder.sv
// SUMP protocol command decoder: assembles short/long commands from the UART byte
// stream and issues one-cycle registered write/command strobes.
module sump_cmd_decoder #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [31:0] config_data,
    output logic [7:0]  opcode,
    output logic        execute,
    output logic        wrDivider,
    output logic        wrSize,
    output logic        wrFlags,
    output logic [3:0]  wrTrigMask,
    output logic [3:0]  wrTrigValue,
    output logic [3:0]  wrTrigConfig,
    output logic        cmd_reset,
    output logic        cmd_arm,
    output logic        cmd_id,
    output logic        cmd_xon,
    output logic        cmd_xoff,
    output logic        cmd_abort,
    output logic        busy
);

    localparam int unsigned TW = 24;

    typedef enum logic {
        IDLE,
        ARG
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [7:0]     pend_q, pend_d;
    logic [23:0]    arg_q, arg_d;

    logic [31:0]    config_d;
    logic [7:0]     opcode_d;
    logic           execute_d;
    logic           wr_divider_d, wr_size_d, wr_flags_d;
    logic [3:0]     wr_trig_mask_d, wr_trig_value_d, wr_trig_config_d;
    logic           cmd_reset_d, cmd_arm_d, cmd_id_d, cmd_xon_d, cmd_xoff_d;
    logic           cmd_abort_d;
    logic           busy_d;

    logic           done;
    logic [7:0]     done_op;

    // State, argument assembly and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            timer_q      <= '0;
            pend_q       <= 8'h00;
            arg_q        <= 24'h0;
            config_data  <= 32'h0;
            opcode       <= 8'h00;
            execute      <= 1'b0;
            wrDivider    <= 1'b0;
            wrSize       <= 1'b0;
            wrFlags      <= 1'b0;
            wrTrigMask   <= 4'h0;
            wrTrigValue  <= 4'h0;
            wrTrigConfig <= 4'h0;
            cmd_reset    <= 1'b0;
            cmd_arm      <= 1'b0;
            cmd_id       <= 1'b0;
            cmd_xon      <= 1'b0;
            cmd_xoff     <= 1'b0;
            cmd_abort    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            pend_q       <= pend_d;
            arg_q        <= arg_d;
            config_data  <= config_d;
            opcode       <= opcode_d;
            execute      <= execute_d;
            wrDivider    <= wr_divider_d;
            wrSize       <= wr_size_d;
            wrFlags      <= wr_flags_d;
            wrTrigMask   <= wr_trig_mask_d;
            wrTrigValue  <= wr_trig_value_d;
            wrTrigConfig <= wr_trig_config_d;
            cmd_reset    <= cmd_reset_d;
            cmd_arm      <= cmd_arm_d;
            cmd_id       <= cmd_id_d;
            cmd_xon      <= cmd_xon_d;
            cmd_xoff     <= cmd_xoff_d;
            cmd_abort    <= cmd_abort_d;
            busy         <= busy_d;
        end
    end

    // Next-state, argument shift and strobe decode
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        timer_d          = timer_q;
        pend_d           = pend_q;
        arg_d            = arg_q;
        config_d         = config_data;
        opcode_d         = opcode;
        execute_d        = 1'b0;
        wr_divider_d     = 1'b0;
        wr_size_d        = 1'b0;
        wr_flags_d       = 1'b0;
        wr_trig_mask_d   = 4'h0;
        wr_trig_value_d  = 4'h0;
        wr_trig_config_d = 4'h0;
        cmd_reset_d      = 1'b0;
        cmd_arm_d        = 1'b0;
        cmd_id_d         = 1'b0;
        cmd_xon_d        = 1'b0;
        cmd_xoff_d       = 1'b0;
        cmd_abort_d      = 1'b0;
        busy_d           = 1'b0;
        done             = 1'b0;
        done_op          = 8'h00;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                idx_d   = 2'd0;
                if (rx_valid) begin
                    if (rx_data[7]) begin
                        pend_d  = rx_data;
                        arg_d   = 24'h0;
                        state_d = ARG;
                    end else begin
                        done    = 1'b1;
                        done_op = rx_data;
                    end
                end
            end
            ARG: begin
                if (rx_valid) begin
                    // Bytes arrive LSB first; shift right so byte 0 ends at [7:0]
                    timer_d = '0;
                    arg_d   = {rx_data, arg_q[23:8]};
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        done     = 1'b1;
                        done_op  = pend_q;
                        config_d = {rx_data, arg_q};
                        state_d  = IDLE;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    cmd_abort_d = 1'b1;
                    timer_d     = '0;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == ARG);

        // Short and long opcodes share one decode: bit 7 keeps them disjoint
        if (done) begin
            execute_d = 1'b1;
            opcode_d  = done_op;
            case (done_op)
                8'h00: cmd_reset_d  = 1'b1;
                8'h01: cmd_arm_d    = 1'b1;
                8'h02: cmd_id_d     = 1'b1;
                8'h11: cmd_xon_d    = 1'b1;
                8'h13: cmd_xoff_d   = 1'b1;
                8'h80: wr_divider_d = 1'b1;
                8'h81: wr_size_d    = 1'b1;
                8'h82: wr_flags_d   = 1'b1;
                default: begin
                    if (done_op[7:4] == 4'hC) begin
                        case (done_op[1:0])
                            2'd0:    wr_trig_mask_d[done_op[3:2]]   = 1'b1;
                            2'd1:    wr_trig_value_d[done_op[3:2]]  = 1'b1;
                            2'd2:    wr_trig_config_d[done_op[3:2]] = 1'b1;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
